// File: rtl/fastpath_train.sv
// Perceptron weight table with a registered read port and a serial
// read-modify-write trainer that adjusts one weight per cycle.
module fastpath_train #(
    parameter int WEIGHT_NUM       = 33,
    parameter int WEIGHT_WIDTH     = 8,
    parameter int WEIGHT_ENTRY_NUM = 64,
    parameter int THETA            = 76,
    parameter int IDX_W            = $clog2(WEIGHT_ENTRY_NUM)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [IDX_W-1:0]                   rd_idx,
    output logic [WEIGHT_NUM*WEIGHT_WIDTH-1:0] rd_w,
    input  logic                               upd_valid,
    output logic                               upd_ready,
    input  logic [IDX_W-1:0]                   upd_idx,
    input  logic                               upd_taken,
    input  logic                               upd_pred,
    input  logic signed [WEIGHT_WIDTH-1:0]     upd_sum,
    input  logic [WEIGHT_NUM-2:0]              upd_hist,
    output logic                               done,
    output logic                               done_trained
);

    localparam int ROW_W = WEIGHT_NUM * WEIGHT_WIDTH;
    localparam int CNT_W = $clog2(WEIGHT_NUM);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WEIGHT_NUM - 1);
    localparam logic [WEIGHT_WIDTH:0] THETA_ABS = (WEIGHT_WIDTH+1)'(THETA);
    localparam logic signed [WEIGHT_WIDTH-1:0] W_MAX = {1'b0, {(WEIGHT_WIDTH-1){1'b1}}};
    localparam logic signed [WEIGHT_WIDTH-1:0] W_MIN = {1'b1, {(WEIGHT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, ADJUST, STORE} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic                   done_trained_q, done_trained_d;
    logic [ROW_W-1:0]       rd_w_q, rd_w_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   taken_q, taken_d;
    logic [WEIGHT_NUM-1:0]  xvec_q, xvec_d;
    logic [ROW_W-1:0]       table_q [WEIGHT_ENTRY_NUM];

    logic                           accept;
    logic                           train;
    logic signed [WEIGHT_WIDTH-1:0] cur_w;

    // Magnitude one bit wider so that the most negative sum maps to +2^(W-1).
    function automatic logic [WEIGHT_WIDTH:0] abs_wide(input logic signed [WEIGHT_WIDTH-1:0] s);
        logic signed [WEIGHT_WIDTH:0] ext;
        ext = {s[WEIGHT_WIDTH-1], s};
        abs_wide = s[WEIGHT_WIDTH-1] ? -ext : ext;
    endfunction

    function automatic logic signed [WEIGHT_WIDTH-1:0] sat_step(
        input logic signed [WEIGHT_WIDTH-1:0] w,
        input logic                           inc
    );
        if (inc)
            sat_step = (w == W_MAX) ? w : w + 1'b1;
        else
            sat_step = (w == W_MIN) ? w : w - 1'b1;
    endfunction

    assign upd_ready    = (state_q == IDLE) && !rst;
    assign rd_w         = rd_w_q;
    assign done         = done_q;
    assign done_trained = done_trained_q;

    always_comb begin
        accept         = upd_valid && upd_ready;
        train          = (upd_taken != upd_pred) || (abs_wide(upd_sum) <= THETA_ABS);
        state_d        = state_q;
        cnt_d          = cnt_q;
        done_d         = 1'b0;
        done_trained_d = 1'b0;
        row_d          = row_q;
        idx_d          = idx_q;
        taken_d        = taken_q;
        xvec_d         = xvec_q;
        cur_w          = row_q[int'(cnt_q)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        rd_w_d         = table_q[rd_idx];

        case (state_q)
            IDLE: begin
                if (accept) begin
                    idx_d   = upd_idx;
                    taken_d = upd_taken;
                    // Bit 0 is the constant bias input, bits 1.. are history.
                    xvec_d  = {upd_hist, 1'b1};
                    if (train)
                        state_d = LOAD;
                    else
                        done_d = 1'b1;
                end
            end
            LOAD: begin
                row_d   = table_q[idx_q];
                cnt_d   = '0;
                state_d = ADJUST;
            end
            ADJUST: begin
                row_d[int'(cnt_q)*WEIGHT_WIDTH +: WEIGHT_WIDTH] =
                    sat_step(cur_w, xvec_q[cnt_q] == taken_q);
                if (cnt_q == CNT_LAST)
                    state_d = STORE;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            STORE: begin
                state_d        = IDLE;
                done_d         = 1'b1;
                done_trained_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            done_q         <= 1'b0;
            done_trained_q <= 1'b0;
            rd_w_q         <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            done_q         <= done_d;
            done_trained_q <= done_trained_d;
            rd_w_q         <= rd_w_d;
        end
    end

    always_ff @(posedge clk) begin
        row_q   <= row_d;
        idx_q   <= idx_d;
        taken_q <= taken_d;
        xvec_q  <= xvec_d;
    end

    // The read port samples the pre-write contents in the STORE cycle; no bypass.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < WEIGHT_ENTRY_NUM; r++)
                table_q[r] <= '0;
        end else if (state_q == STORE) begin
            table_q[idx_q] <= row_q;
        end
    end

endmodule

// File: tb/tb_fastpath_train.sv
// Scoreboard bench for fastpath_train: expected retirements are queued at
// drive time and matched against done/done_trained and their cycle.
module tb_fastpath_train;

    localparam int WN  = 33;
    localparam int WW  = 8;
    localparam int EN  = 64;
    localparam int IW  = 6;
    localparam int LAT = WN + 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [IW-1:0]     rd_idx = '0;
    logic [WN*WW-1:0]  rd_w;
    logic              upd_valid = 1'b0;
    logic              upd_ready;
    logic [IW-1:0]     upd_idx = '0;
    logic              upd_taken = 1'b0;
    logic              upd_pred = 1'b0;
    logic [WW-1:0]     upd_sum = '0;
    logic [WN-2:0]     upd_hist = '0;
    logic              done;
    logic              done_trained;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    int done_seen = 0;

    bit exp_tr_q[$];
    int exp_cy_q[$];
    int mdl[EN][WN];

    fastpath_train dut (
        .clk          (clk),
        .rst          (rst),
        .rd_idx       (rd_idx),
        .rd_w         (rd_w),
        .upd_valid    (upd_valid),
        .upd_ready    (upd_ready),
        .upd_idx      (upd_idx),
        .upd_taken    (upd_taken),
        .upd_pred     (upd_pred),
        .upd_sum      (upd_sum),
        .upd_hist     (upd_hist),
        .done         (done),
        .done_trained (done_trained)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Retirement monitor: every done must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            bit e_tr;
            int e_cy;
            done_seen++;
            total_cnt++;
            if (exp_tr_q.size() == 0) begin
                $display("FAIL spurious_done: done=1 at cycle %0d, no retirement expected", cyc);
            end else begin
                e_tr = exp_tr_q.pop_front();
                e_cy = exp_cy_q.pop_front();
                if (done_trained !== e_tr || cyc != e_cy)
                    $display("FAIL retire: done_trained=%b at cycle %0d, expected %b at cycle %0d",
                             done_trained, cyc, e_tr, e_cy);
                else
                    pass_cnt++;
            end
        end
    end

    function automatic logic [WN*WW-1:0] mdl_row(input int idx);
        logic [WN*WW-1:0] r;
        for (int k = 0; k < WN; k++)
            r[k*WW +: WW] = WW'(mdl[idx][k]);
        return r;
    endfunction

    function automatic bit model_update(input int idx, input logic taken, input logic pred,
                                        input logic [WW-1:0] sum, input logic [WN-2:0] hist);
        int s, a, x;
        bit tr;
        s  = int'($signed(sum));
        a  = (s < 0) ? -s : s;
        tr = (taken != pred) || (a <= 76);
        if (tr) begin
            for (int k = 0; k < WN; k++) begin
                x = (k == 0) ? 1 : int'(hist[k-1]);
                if (x == int'(taken))
                    mdl[idx][k] = (mdl[idx][k] >= 127) ? 127 : mdl[idx][k] + 1;
                else
                    mdl[idx][k] = (mdl[idx][k] <= -128) ? -128 : mdl[idx][k] - 1;
            end
        end
        return tr;
    endfunction

    task automatic do_update(input logic [IW-1:0] idx, input logic taken, input logic pred,
                             input logic [WW-1:0] sum, input logic [WN-2:0] hist,
                             output int acc_cyc);
        int  n;
        bit  tr;
        n = 0;
        @(negedge clk);
        while (upd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (upd_ready !== 1'b1) begin
            total_cnt++;
            $display("FAIL ready_timeout: upd_ready=%b, expected 1 within 100 cycles", upd_ready);
        end
        upd_valid = 1'b1;
        upd_idx   = idx;
        upd_taken = taken;
        upd_pred  = pred;
        upd_sum   = sum;
        upd_hist  = hist;
        tr        = model_update(int'(idx), taken, pred, sum, hist);
        acc_cyc   = cyc;
        exp_tr_q.push_back(tr);
        exp_cy_q.push_back(cyc + (tr ? LAT : 1));
        @(posedge clk);
        #1 upd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_tr_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_tr_q.size() != 0) begin
            total_cnt++;
            $display("FAIL idle_timeout: %0d retirements outstanding, expected 0", exp_tr_q.size());
            exp_tr_q.delete();
            exp_cy_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic read_row(input logic [IW-1:0] idx, output logic [WN*WW-1:0] r);
        @(negedge clk);
        rd_idx = idx;
        @(negedge clk);
        r = rd_w;
    endtask

    task automatic test_reset();
        logic [WN*WW-1:0] r;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (upd_ready !== 1'b0) $display("FAIL reset_ready: upd_ready=%b, expected 0", upd_ready);
        else pass_cnt++;
        total_cnt++;
        if (done !== 1'b0 || done_trained !== 1'b0)
            $display("FAIL reset_done: done=%b done_trained=%b, expected 0 0", done, done_trained);
        else pass_cnt++;
        rst = 1'b0;
        rd_idx = 6'd5;
        @(negedge clk);
        r = rd_w;
        total_cnt++;
        if (r !== '0) $display("FAIL reset_rd_w: rd_w=%h, expected 0", r);
        else pass_cnt++;
        total_cnt++;
        if (upd_ready !== 1'b1 || done !== 1'b0)
            $display("FAIL post_reset: upd_ready=%b done=%b, expected 1 0", upd_ready, done);
        else pass_cnt++;
    endtask

    task automatic test_mispredict();
        logic [WN*WW-1:0] r;
        int a;
        do_update(6'd3, 1'b1, 1'b0, 8'hF6, {(WN-1){1'b1}}, a);
        wait_idle();
        read_row(6'd3, r);
        total_cnt++;
        if (r !== {WN{8'h01}}) $display("FAIL mispredict_row: rd_w=%h, expected all 01", r);
        else pass_cnt++;
    endtask

    task automatic test_threshold();
        logic [WN*WW-1:0] r;
        int a;
        do_update(6'd4, 1'b1, 1'b1, 8'd100, 32'hA5A5_0F0F, a);
        do_update(6'd4, 1'b1, 1'b1, 8'd76,  32'hA5A5_0F0F, a);
        do_update(6'd4, 1'b1, 1'b1, 8'h80,  32'hA5A5_0F0F, a);
        do_update(6'd4, 1'b0, 1'b0, 8'hB4,  32'h0000_FFFF, a);
        do_update(6'd4, 1'b0, 1'b0, 8'd77,  32'h0000_FFFF, a);
        wait_idle();
        read_row(6'd4, r);
        total_cnt++;
        if (r !== mdl_row(4)) $display("FAIL threshold_row: rd_w=%h, expected %h", r, mdl_row(4));
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            total_cnt++;
            if (upd_ready !== 1'b1) $display("FAIL b2b_ready: upd_ready=%b, expected 1", upd_ready);
            else pass_cnt++;
            upd_valid = 1'b1;
            upd_idx   = IW'(20 + j);
            upd_taken = j[0];
            upd_pred  = j[0];
            upd_sum   = 8'd90;
            upd_hist  = 32'h1234_5678;
            exp_tr_q.push_back(1'b0);
            exp_cy_q.push_back(cyc + 1);
        end
        @(negedge clk);
        upd_valid = 1'b0;
        wait_idle();
    endtask

    task automatic test_saturation();
        logic [WN*WW-1:0] r;
        logic [WN*WW-1:0] sat;
        int a;
        sat = {{(WN-2){8'h80}}, 8'h7F, 8'h7F};
        for (int j = 0; j < 130; j++)
            do_update(6'd7, 1'b1, 1'b0, 8'd0, 32'h0000_0001, a);
        wait_idle();
        read_row(6'd7, r);
        total_cnt++;
        if (r !== sat) $display("FAIL sat_row: rd_w=%h, expected %h", r, sat);
        else pass_cnt++;
        do_update(6'd7, 1'b1, 1'b0, 8'd0, 32'h0000_0001, a);
        wait_idle();
        read_row(6'd7, r);
        total_cnt++;
        if (r !== sat) $display("FAIL sat_hold: rd_w=%h, expected %h", r, sat);
        else pass_cnt++;
    endtask

    task automatic test_collision();
        logic [WN*WW-1:0] old_row;
        logic [WN*WW-1:0] new_row;
        logic [WN*WW-1:0] r;
        int a;
        bit tr;
        @(negedge clk);
        rd_idx  = 6'd3;
        old_row = mdl_row(3);
        do_update(6'd3, 1'b0, 1'b1, 8'd5, 32'h5555_AAAA, a);
        new_row = mdl_row(3);
        while (cyc < a + 10) @(negedge clk);
        upd_valid = 1'b1;
        upd_idx   = 6'd10;
        upd_taken = 1'b1;
        upd_pred  = 1'b1;
        upd_sum   = 8'd100;
        upd_hist  = 32'h0;
        total_cnt++;
        if (upd_ready !== 1'b0) $display("FAIL adjust_ready: upd_ready=%b, expected 0", upd_ready);
        else pass_cnt++;
        while (cyc < a + LAT) @(negedge clk);
        r = rd_w;
        total_cnt++;
        if (r !== old_row) $display("FAIL collision_old: rd_w=%h, expected %h", r, old_row);
        else pass_cnt++;
        total_cnt++;
        if (upd_ready !== 1'b1) $display("FAIL ready_return: upd_ready=%b, expected 1", upd_ready);
        else pass_cnt++;
        tr = model_update(10, 1'b1, 1'b1, 8'd100, 32'h0);
        exp_tr_q.push_back(tr);
        exp_cy_q.push_back(cyc + 1);
        @(posedge clk);
        #1 upd_valid = 1'b0;
        @(negedge clk);
        r = rd_w;
        total_cnt++;
        if (r !== new_row) $display("FAIL collision_new: rd_w=%h, expected %h", r, new_row);
        else pass_cnt++;
        wait_idle();
    endtask

    task automatic test_reset_mid();
        logic [WN*WW-1:0] r;
        int a;
        int seen0;
        @(negedge clk);
        rd_idx = 6'd3;
        do_update(6'd9, 1'b1, 1'b0, 8'd0, 32'hFFFF_0000, a);
        while (cyc < a + 15) @(negedge clk);
        rst = 1'b1;
        exp_tr_q.delete();
        exp_cy_q.delete();
        for (int i = 0; i < EN; i++)
            for (int k = 0; k < WN; k++)
                mdl[i][k] = 0;
        seen0 = done_seen;
        @(negedge clk);
        total_cnt++;
        if (upd_ready !== 1'b0 || rd_w !== '0)
            $display("FAIL mid_reset: upd_ready=%b rd_w=%h, expected 0 and 0", upd_ready, rd_w);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (upd_ready !== 1'b1 || done !== 1'b0)
            $display("FAIL after_reset: upd_ready=%b done=%b, expected 1 0", upd_ready, done);
        else pass_cnt++;
        repeat (45) @(negedge clk);
        total_cnt++;
        if (done_seen != seen0) $display("FAIL discarded_done: %0d dones, expected 0", done_seen - seen0);
        else pass_cnt++;
        read_row(6'd9, r);
        total_cnt++;
        if (r !== '0) $display("FAIL cleared_row9: rd_w=%h, expected 0", r);
        else pass_cnt++;
        read_row(6'd7, r);
        total_cnt++;
        if (r !== '0) $display("FAIL cleared_row7: rd_w=%h, expected 0", r);
        else pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < EN; i++)
            for (int k = 0; k < WN; k++)
                mdl[i][k] = 0;
        test_reset();
        test_mispredict();
        test_threshold();
        test_back_to_back();
        test_saturation();
        test_collision();
        test_reset_mid();
        wait_idle();
        total_cnt++;
        if (exp_tr_q.size() != 0) $display("FAIL leftover: %0d outstanding, expected 0", exp_tr_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fastpath_train.md
# fastpath_train

Training and weight-storage unit for the fast-path perceptron predictor. It holds the per-branch weight table. It supplies a registered weight row to the prediction stage and applies the perceptron learning rule when a branch resolves. Resolved branches arrive over a valid/ready handshake. Each accepted update either retires immediately or runs a multi-cycle read-modify-write of one table row.

## Interface
- WEIGHT_NUM, 33, weights per row (index 0 = bias, 1..32 = history positions)
- WEIGHT_WIDTH, 8, two's-complement bits per weight
- WEIGHT_ENTRY_NUM, 64, table rows; IDX_W = clog2(WEIGHT_ENTRY_NUM)
- THETA, 76, training threshold on |sum|

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rd_idx  in  IDX_W  row requested by predictor
- rd_w  out  WEIGHT_NUM*WEIGHT_WIDTH  registered row; weight i at bits [i*W+W-1 : i*W]
- upd_valid  in  1  resolved-branch update offered
- upd_ready  out  1  unit can accept an update
- upd_idx  in  IDX_W  row to train
- upd_taken  in  1  actual outcome (1 = taken)
- upd_pred  in  1  prediction that was made
- upd_sum  in  WEIGHT_WIDTH  signed perceptron output used for that prediction
- upd_hist  in  WEIGHT_NUM-1  global history; bit k drives weight k+1 (1 = taken)
- done  out  1  one-cycle pulse when an accepted update retires
- done_trained  out  1  valid with done; 1 = row was modified

## Operation
- States: IDLE, LOAD, ADJUST, STORE. upd_ready = (state == IDLE). Accept = upd_valid & upd_ready.
- On accept, capture idx/taken/hist. Train condition: (upd_taken != upd_pred) or |upd_sum| <= THETA. |−2^(W−1)| is 2^(W−1); compute it at W+1 bits.
- No train: stay IDLE. The next cycle gives done=1 with done_trained=0. The table is unchanged.
- Train: IDLE→LOAD. LOAD copies table[idx] into the working row, then →ADJUST with counter i=0.
- ADJUST handles one weight per cycle, i = 0..WEIGHT_NUM−1:
  - x_0 = 1; x_i = hist[i−1].
  - If x_i == taken, w_i += 1; else w_i −= 1.
  - Saturate to [−2^(W−1), 2^(W−1)−1]: 127 stays 127 on increment, −128 stays −128 on decrement.
  - After i = WEIGHT_NUM−1, go to STORE.
- STORE writes the working row to table[idx] and goes to IDLE. done=1 and done_trained=1 in the following cycle.
- Read port: rd_w <= table[rd_idx] every cycle, regardless of state.
- Read/write collision: if rd_idx == idx in the STORE cycle, rd_w gets the old row. The new row is visible to a read issued one cycle later. There is no bypass.
- upd_valid in a non-IDLE state is ignored. The producer must hold it until ready.
- Reset, including mid-operation: all table rows are cleared to 0 and rd_w is cleared to 0. State goes to IDLE with i=0 and done=0. An in-flight update is discarded and no done is issued.

## Timing
- Accept at cycle T, no train: done at T+1; upd_ready stays high, so back-to-back accepts are allowed.
- Accept at T, train:
  - LOAD at T+1.
  - ADJUST T+2 … T+1+WEIGHT_NUM, which is T+34 for the default.
  - STORE at T+35.
  - done and upd_ready high at T+36.
- Throughput: one training update per WEIGHT_NUM+3 cycles.
- Reset values: upd_ready 0 during the reset cycle, 1 afterwards. done 0, done_trained 0, rd_w all zeros.
- rd_w latency is one cycle from rd_idx.

## Test plan
- Reset, then rd_idx=5 → rd_w=0 on the next cycle; upd_ready=1 and done=0.
- Mispredict on idx 3: taken=1, pred=0, sum=−10, hist=all-ones. Expect done at T+36 with done_trained=1, and row 3 all weights = +1. Read idx 3 → 33×8'h01.
- Confident correct update: taken=1, pred=1, sum=100. Expect done at T+1 with done_trained=0, row unchanged. Repeat with sum=76 → training occurs (boundary inclusive). Repeat with sum=−128 → no training.
- Saturation: preload row 7 by 130 identical trainings with taken=1 and hist=0x0000_0001. Expect w0=127, w1=127, and w2..w32=−128. One further identical training leaves the row unchanged.
- Collision: rd_idx=3 held while STORE writes row 3. rd_w shows the old row for the STORE-cycle read and the new row one cycle later. upd_valid asserted mid-ADJUST is not accepted until upd_ready returns.
- Assert rst during ADJUST on idx 9. Expect no done, the table all zero, and upd_ready=1 the cycle after rst deasserts.
